xorshift32_rewind: RTL and testbench

Reverse stepper for the xorshift32 generator. It takes a 32-bit generator state and walks it backwards a programmable number of steps, returning the state that produced it. It sits beside the forward `xorshift32` generator and is used to:
- recover a seed from an observed random word;
- replay or rewind test-matrix streams;
- self-check the generator in-system.

---
 rtl/xorshift32_rewind.sv | 106 ++++++++++
 tb/tb_xorshift32_rewind.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/xorshift32_rewind.sv
// Iterative reverse stepper for xorshift32: undoes one generator step every three clocks.
// Each sub-step applies one inverse shift-xor stage to the working register.
module xorshift32_rewind #(
    parameter int unsigned STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       state_in,
    input  logic [STEP_W-1:0] steps,
    output logic              busy,
    output logic              done,
    output logic [31:0]       state_out
);

    typedef enum logic [2:0] {
        StIdle,
        StU5,
        StU17,
        StU13,
        StFin
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       work_q, work_d;
    logic [STEP_W-1:0] remaining_q, remaining_d;
    logic [31:0]       out_q, out_d;

    // Inverse of t ^= t << 5: fold in every multiple of 5 that still fits in 32 bits.
    function automatic logic [31:0] inv_u5(input logic [31:0] y);
        return y ^ (y << 5) ^ (y << 10) ^ (y << 15) ^ (y << 20) ^ (y << 25) ^ (y << 30);
    endfunction

    function automatic logic [31:0] inv_u17(input logic [31:0] y);
        return y ^ (y >> 17);
    endfunction

    function automatic logic [31:0] inv_u13(input logic [31:0] y);
        return y ^ (y << 13) ^ (y << 26);
    endfunction

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        remaining_d = remaining_q;
        out_d       = out_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    work_d      = state_in;
                    remaining_d = steps;
                    if (steps == '0) begin
                        out_d   = state_in;
                        state_d = StFin;
                    end else begin
                        state_d = StU5;
                    end
                end
            end
            StU5: begin
                work_d  = inv_u5(work_q);
                state_d = StU17;
            end
            StU17: begin
                work_d  = inv_u17(work_q);
                state_d = StU13;
            end
            StU13: begin
                work_d      = inv_u13(work_q);
                remaining_d = remaining_q - STEP_W'(1);
                if (remaining_q == STEP_W'(1)) begin
                    // Capture on FIN entry so the result is visible alongside done.
                    out_d   = inv_u13(work_q);
                    state_d = StFin;
                end else begin
                    state_d = StU5;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            work_q      <= 32'h0;
            remaining_q <= '0;
            out_q       <= 32'h0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            remaining_q <= remaining_d;
            out_q       <= out_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StFin);
    assign state_out = out_q;

endmodule

// File: tb/tb_xorshift32_rewind.sv
// Self-checking bench for xorshift32_rewind: directed vectors, timing, busy/reset behaviour,
// and randomized round trips against a forward xorshift32 model.
module tb_xorshift32_rewind;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] state_in;
    logic [15:0] steps;
    logic        busy;
    logic        done;
    logic [31:0] state_out;

    int n_cmp = 0;
    int n_err = 0;

    xorshift32_rewind #(
        .STEP_W(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .state_in (state_in),
        .steps    (steps),
        .busy     (busy),
        .done     (done),
        .state_out(state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fwd_step(input logic [31:0] s);
        logic [31:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    function automatic logic [31:0] fwd_n(input logic [31:0] s, input int n);
        logic [31:0] t;
        t = s;
        for (int i = 0; i < n; i++) t = fwd_step(t);
        return t;
    endfunction

    // Issue one request, then follow it cycle by cycle until done (bounded).
    task automatic run_op(input string tag, input logic [31:0] s, input int n,
                          input logic [31:0] exp);
        int lat;
        bit busy_drop;
        busy_drop = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        state_in = s;
        steps    = 16'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 3 * n + 10) begin
            if (!busy) busy_drop = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'(3 * n + 1));
        check_eq({tag, "_busy_held"}, 64'(busy_drop), 64'd0);
        check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd1);
        check_eq({tag, "_state_out"}, 64'(state_out), 64'(exp));
        @(posedge clk);
        #1;
        check_eq({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_idle_done"}, 64'(done), 64'd0);
        check_eq({tag, "_hold"}, 64'(state_out), 64'(exp));
    endtask

    initial begin
        logic [31:0] seed;
        logic [31:0] first_in;
        int          k;
        int          done_cnt;
        int          done_cyc;
        bit          busy_early;

        rst      = 1'b1;
        start    = 1'b0;
        state_in = 32'h0;
        steps    = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_state_out", 64'(state_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("single", 32'h00042021, 1, 32'h00000001);
        run_op("two", 32'h04080601, 2, 32'h00000001);
        run_op("two_by_one", 32'h04080601, 1, 32'h00042021);
        run_op("zero_steps", 32'hDEADBEEF, 0, 32'hDEADBEEF);
        run_op("fixed_zero", 32'h0, 100, 32'h0);

        // Round trip: four forward draws per generator pulse, so rewind by 4K.
        for (int i = 0; i < 40; i++) begin
            seed = $urandom;
            k    = $urandom_range(1, 6);
            run_op($sformatf("rt%0d", i), fwd_n(seed, 4 * k), 4 * k, seed);
        end
        for (int i = 0; i < 10; i++) begin
            seed = $urandom;
            k    = $urandom_range(0, 20);
            run_op($sformatf("rnd%0d", i), fwd_n(seed, k), k, seed);
        end

        // Start while busy: extra pulses in cycles 3, 10 and 16 must be ignored.
        first_in   = $urandom;
        done_cnt   = 0;
        done_cyc   = -1;
        busy_early = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        state_in = fwd_n(first_in, 5);
        steps    = 16'd5;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (c <= 16 && !busy) busy_early = 1'b1;
            start    = (c == 3 || c == 10 || c == 16);
            state_in = $urandom;
            steps    = 16'd1;
        end
        start = 1'b0;
        check_eq("busy_done_count", 64'(done_cnt), 64'd1);
        check_eq("busy_done_cycle", 64'(done_cyc), 64'd16);
        check_eq("busy_never_dropped", 64'(busy_early), 64'd0);
        check_eq("busy_result", 64'(state_out), 64'(first_in));

        // Reset in cycle 6 of a 10-step rewind.
        done_cnt = 0;
        @(negedge clk);
        start    = 1'b1;
        state_in = $urandom;
        steps    = 16'd10;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) done_cnt++;
            if (c == 6) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_mid_busy", 64'(busy), 64'd0);
        check_eq("rst_mid_done", 64'(done), 64'd0);
        check_eq("rst_mid_state_out", 64'(state_out), 64'd0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check_eq("rst_mid_no_done", 64'(done_cnt), 64'd0);
        run_op("after_rst", 32'h00042021, 1, 32'h00000001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
